wb_copy_master: RTL and testbench



---
 rtl/wb_copy_pkg.sv | 6 +
 rtl/wb_if.sv | 15 +
 rtl/sync_fifo.sv | 38 +++
 rtl/wb_copy_master.sv | 150 +++++++++++++++
 tb/tb_wb_copy_master.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_copy_pkg.sv
// wb_copy_pkg: shared types and constants for the Wishbone copy master
package wb_copy_pkg;
  typedef enum logic [2:0] {IDLE, RD, GAP, WR, FIN} state_t;
  localparam int WORD_BYTES = 4;
  localparam logic [3:0] SEL_ALL = 4'hF;
endpackage

// File: rtl/wb_if.sv
// wb_if: Wishbone pipelined-mode bus with initiator and target views
interface wb_if (input logic clk);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        stall;
  logic        err;
  modport master (input clk, dat_i, ack, stall, err, output cyc, stb, we, adr, sel, dat_o);
  modport slave (input clk, cyc, stb, we, adr, sel, dat_o, output dat_i, ack, stall, err);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through word buffer with flush
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];
  assign empty = wr_q == rd_q;
  assign full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  // Pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + 1'b1;
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  // Storage needs no reset; only valid entries are ever read out
  always_ff @(posedge clk)
    if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/wb_copy_master.sv
// wb_copy_master: chunked Wishbone block copy, read a chunk then write it back out
module wb_copy_master
  import wb_copy_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  wb_if.master             wb
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t           state_q;
  logic             busy_q, done_q, error_q, cyc_q, stb_q, we_q;
  logic [31:0]      adr_q, dat_o_q, src_q, dst_q;
  logic [LEN_W-1:0] rem_q;
  logic [CW-1:0]    chunk_q, issued_q, acked_q, issued_nx, acked_nx;
  logic             acc, ack_v, err_v, fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [31:0]      fifo_dout;
  function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] n);
    return (n > LEN_W'(DEPTH)) ? CW'(DEPTH) : CW'(n);
  endfunction
  assign acc       = stb_q && !wb.stall;
  assign ack_v     = wb.ack && cyc_q && (issued_q != acked_q);
  assign err_v     = wb.err && cyc_q && (issued_q != acked_q);
  assign issued_nx = issued_q + 1'b1;
  assign acked_nx  = acked_q + 1'b1;
  assign fifo_push = (state_q == RD) && ack_v && !err_v;
  assign fifo_pop  = ((state_q == GAP) && !fifo_empty) ||
                     ((state_q == WR) && acc && !err_v && (issued_nx != chunk_q));
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign wb.cyc    = cyc_q;
  assign wb.stb    = stb_q;
  assign wb.we     = we_q;
  assign wb.adr    = adr_q;
  assign wb.dat_o  = dat_o_q;
  assign wb.sel    = SEL_ALL;
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst_n(rst_n), .push(fifo_push), .pop(fifo_pop), .flush(err_v),
    .din(wb.dat_i), .dout(fifo_dout), .empty(fifo_empty), .full(fifo_full)
  );
  // Copy sequencer: every bus output is a register; write data is preloaded from the buffer head
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_o_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      chunk_q  <= '0;
      issued_q <= '0;
      acked_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          error_q  <= 1'b0;
          src_q    <= src_addr & ~32'h3;
          dst_q    <= dst_addr & ~32'h3;
          rem_q    <= len_words;
          issued_q <= '0;
          acked_q  <= '0;
          if (len_words == '0) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q <= RD;
            busy_q  <= 1'b1;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= src_addr & ~32'h3;
            chunk_q <= chunk_of(len_words);
          end
        end
        RD, WR: if (err_v) begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= FIN;
        end else begin
          if (acc) begin
            adr_q    <= adr_q + 32'(WORD_BYTES);
            issued_q <= issued_nx;
            if (issued_nx == chunk_q) stb_q <= 1'b0;
            else if (state_q == WR) dat_o_q <= fifo_dout;
          end
          if (ack_v) begin
            acked_q <= acked_nx;
            if (acked_nx == chunk_q) begin
              cyc_q   <= 1'b0;
              state_q <= GAP;
              if (state_q == RD) src_q <= adr_q;
              else begin
                dst_q <= adr_q;
                rem_q <= rem_q - LEN_W'(chunk_q);
              end
            end
          end
        end
        GAP: begin
          issued_q <= '0;
          acked_q  <= '0;
          if (!fifo_empty) begin
            state_q <= WR;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= dst_q;
            dat_o_q <= fifo_dout;
          end else if (rem_q == '0) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= RD;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= src_q;
            chunk_q <= chunk_of(rem_q);
          end
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  // A response with nothing outstanding is a target protocol violation
  assert property (@(posedge clk) disable iff (!rst_n) (wb.ack || wb.err) |-> (cyc_q && issued_q != acked_q));
  // Outstanding reads never exceed the chunk, so the buffer cannot overflow
  assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));
endmodule

// File: tb/tb_wb_copy_master.sv
// tb_wb_copy_master: scoreboard bench with a stalling, delaying Wishbone memory target
module tb_wb_copy_master;
  localparam int DEPTH = 8;
  localparam int LEN_W = 16;
  typedef struct packed { logic we; logic [31:0] adr; logic [31:0] dat; } req_t;
  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; int dly; } pend_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [LEN_W-1:0] len_words = '0;
  logic busy, done, error;
  int n_cmp = 0;
  int n_bad = 0;
  int stall_pct = 0;
  int max_dly = 0;
  int err_at = 0;
  int wr_cnt = 0;
  bit err_chk = 0;
  bit held = 0;
  req_t hold;
  req_t exp_q[$];
  pend_t pend_q[$];
  logic [31:0] mem [logic [31:0]];
  wb_if bus (.clk(clk));
  wb_copy_master #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .busy(busy), .done(done), .error(error), .wb(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction
  task automatic push_exp(input logic [31:0] s, input logic [31:0] d, input int n);
    req_t r;
    for (int b = 0; b < n; b += DEPTH) begin
      int c = (n - b < DEPTH) ? n - b : DEPTH;
      for (int i = 0; i < c; i++) begin
        r = '{1'b0, s + 32'(4 * (b + i)), 32'h0};
        exp_q.push_back(r);
      end
      for (int i = 0; i < c; i++) begin
        r = '{1'b1, d + 32'(4 * (b + i)), mem_rd(s + 32'(4 * (b + i)))};
        exp_q.push_back(r);
      end
    end
  endtask
  task automatic slave_step();
    pend_t p;
    req_t r;
    if (err_chk) begin
      check("cyc_after_err", bus.cyc, 1'b0);
      check("stb_after_err", bus.stb, 1'b0);
      err_chk = 0;
    end
    bus.ack = 1'b0;
    bus.err = 1'b0;
    if (!bus.cyc) pend_q.delete();
    else if (pend_q.size() != 0) begin
      if (pend_q[0].dly == 0) begin
        p = pend_q.pop_front();
        if (p.we) begin
          wr_cnt++;
          if (wr_cnt == err_at) begin
            bus.err = 1'b1;
            err_chk = 1;
          end else begin
            mem[p.adr] = p.dat;
            bus.ack = 1'b1;
          end
        end else begin
          bus.dat_i = mem_rd(p.adr);
          bus.ack = 1'b1;
        end
      end else pend_q[0].dly--;
    end
    bus.stall = ($urandom_range(99) < stall_pct);
    if (bus.cyc && bus.stb) begin
      if (held) check("stall_hold", {bus.adr, bus.dat_o}, {hold.adr, hold.dat});
      if (!bus.stall) begin
        held = 0;
        if (exp_q.size() == 0) check("unexpected_req", {bus.we, bus.adr}, 33'h0);
        else begin
          r = exp_q.pop_front();
          check("req_we_adr", {bus.we, bus.adr}, {r.we, r.adr});
          if (r.we) check("req_dat", bus.dat_o, r.dat);
        end
        p = '{bus.we, bus.adr, bus.dat_o, int'($urandom_range(max_dly))};
        pend_q.push_back(p);
        check("outstanding_le_depth", pend_q.size() <= DEPTH, 1'b1);
      end else begin
        held = 1;
        hold = '{bus.we, bus.adr, bus.dat_o};
      end
    end else held = 0;
  endtask
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit exp_err, input int poke);
    logic [31:0] sw[$];
    int bursts, dones;
    bit any_busy, pc;
    for (int i = 0; i < n; i++) sw.push_back(mem_rd(s + 32'(4 * i)));
    push_exp(s, d, n);
    @(negedge clk);
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    len_words = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    bursts = 0;
    any_busy = 0;
    pc = 0;
    for (int t = 0; t < 4000 && !done; t++) begin
      if (bus.cyc && !pc) bursts++;
      pc = bus.cyc;
      any_busy |= busy;
      if (t == poke) begin
        start = 1'b1;
        src_addr = 32'hDEAD_0000;
        len_words = 3;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", done, 1'b1);
    check("error_flag", error, exp_err);
    check("busy_at_done", busy, 1'b0);
    if (!exp_err) begin
      check("cyc_bursts", bursts, 2 * ((n + DEPTH - 1) / DEPTH));
      check("busy_seen", any_busy, 1'b1);
      check("sb_drained", exp_q.size(), 0);
      for (int i = 0; i < n; i++) check("dst_word", mem_rd(d + 32'(4 * i)), sw[i]);
    end
    exp_q.delete();
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dones += int'(done);
    end
    check("single_done", dones, 0);
  endtask
  initial begin
    bus.ack = 1'b0;
    bus.err = 1'b0;
    bus.stall = 1'b0;
    bus.dat_i = '0;
    forever @(negedge clk) slave_step();
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bit quiet;
    int dones;
    #1 rst_n = 1'b0;
    #2;
    check("reset_ctl", {bus.cyc, bus.stb, bus.we, busy, done, error, bus.sel}, {6'b0, 4'hF});
    check("reset_adr_dat", {bus.adr, bus.dat_o}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_copy(32'h0000_0000, 32'h0000_0100, 4, 1'b0, -1);
    run_copy(32'h0000_1000, 32'h0000_1400, 10, 1'b0, 5);
    stall_pct = 50;
    max_dly = 3;
    run_copy(32'h0000_2000, 32'h0000_3000, 37, 1'b0, -1);
    stall_pct = 0;
    max_dly = 0;
    wr_cnt = 0;
    err_at = 3;
    run_copy(32'h0000_0600, 32'h0000_0700, 8, 1'b1, -1);
    err_at = 0;
    run_copy(32'h0000_0680, 32'h0000_0780, 1, 1'b0, -1);
    @(negedge clk);
    start = 1'b1;
    len_words = '0;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", done, 1'b1);
    quiet = busy | bus.cyc;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      quiet |= busy | bus.cyc;
      dones += int'(done);
    end
    check("len0_quiet", quiet, 1'b0);
    check("len0_single_done", dones, 0);
    run_copy(32'hFFFF_FFF8, 32'h0000_0800, 4, 1'b0, -1);
    push_exp(32'h0000_0A00, 32'h0000_0B00, 8);
    @(negedge clk);
    start = 1'b1;
    src_addr = 32'h0000_0A00;
    dst_addr = 32'h0000_0B00;
    len_words = 8;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 200 && !(bus.cyc && bus.we); t++) @(negedge clk);
    check("reached_wr", bus.cyc && bus.we, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midwr_rst_ctl", {bus.cyc, bus.stb, bus.we, busy, done, error, bus.sel}, {6'b0, 4'hF});
    check("midwr_rst_adr_dat", {bus.adr, bus.dat_o}, 64'h0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_copy(32'h0000_0C00, 32'h0000_0C80, 3, 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
